// File: rtl/retire_positioner.sv
// retire_positioner
//   Drain-side counterpart of the issue positioner. Walks the allocators of a
//   computed batch in one-hot order, reads one result from each, tags it with
//   its output-map coordinate and linear address, and streams it out with a
//   valid/ready handshake. The center raster matches the issue side exactly.
//
//   Optional feature macro: RETIRE_RELU_EN
//     defined   : negative results are clamped to zero at capture
//     undefined : results pass through verbatim
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   image_dim         input image side length (sampled during reset)
//   padding           first center coordinate (sampled during reset)
//   stride            center step 1..7 (sampled during reset)
//   batch_ready       current batch computed, may be drained
//   allocator_select  one-hot read select, bit k = allocator k
//   alloc_result      result of the selected allocator
//   alloc_valid       alloc_result valid for the current select
//   out_data          result to output buffer
//   out_x, out_y      output column/row index
//   out_addr          linear address out_y*row_len + out_x
//   out_valid         out_* valid
//   out_ready         output buffer accepts
//   batch_done        one-cycle pulse when a batch has been fully retired
//   done              level, whole map retired
//
// state  | meaning
// IDLE   | waiting for batch_ready
// SELECT | select bit k driven, waiting for alloc_valid
// SEND   | result presented, waiting for out_ready
// BEND   | batch boundary, batch_done pulse, k cleared
// FIN    | whole map retired, done held until reset
module retire_positioner #(
  parameter int NUM_ALLOCATORS = 220,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                image_dim,
  input  logic [1:0]                padding,
  input  logic [2:0]                stride,
  input  logic                      batch_ready,
  output logic [NUM_ALLOCATORS-1:0] allocator_select,
  input  logic [DATA_WIDTH-1:0]     alloc_result,
  input  logic                      alloc_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [7:0]                out_x,
  output logic [7:0]                out_y,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      batch_done,
  output logic                      done
);

  localparam int K_W = (NUM_ALLOCATORS > 1) ? $clog2(NUM_ALLOCATORS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_ALLOCATORS - 1);
  localparam logic [NUM_ALLOCATORS-1:0] SEL_ONE = NUM_ALLOCATORS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SEND,
    S_BEND,
    S_FIN
  } state_t;

  state_t          state;
  logic [K_W-1:0]  k;
  logic [K_W-1:0]  k_next;
  logic [7:0]      cfg_dim;
  logic [1:0]      cfg_pad;
  logic [2:0]      cfg_stride;
  logic [8:0]      center_x;
  logic [8:0]      center_y;
  logic [8:0]      limit;
  logic [8:0]      x_step;
  logic [8:0]      y_step;
  logic            last_x;
  logic            last_y;
  logic [DATA_WIDTH-1:0] captured;

  // 9-bit compare so image_dim=255 plus padding cannot wrap
  assign limit  = {1'b0, cfg_dim} - 9'd1 + {7'd0, cfg_pad};
  assign x_step = center_x + {6'd0, cfg_stride};
  assign y_step = center_y + {6'd0, cfg_stride};
  assign last_x = (x_step > limit);
  assign last_y = (y_step > limit);
  assign k_next = k + K_W'(1);

`ifdef RETIRE_RELU_EN
  assign captured = alloc_result[DATA_WIDTH-1] ? '0 : alloc_result;
`else
  assign captured = alloc_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      k                <= '0;
      cfg_dim          <= image_dim;
      cfg_pad          <= padding;
      cfg_stride       <= stride;
      center_x         <= {7'd0, padding};
      center_y         <= {7'd0, padding};
      allocator_select <= '0;
      out_data         <= '0;
      out_x            <= '0;
      out_y            <= '0;
      out_addr         <= '0;
      out_valid        <= 1'b0;
      batch_done       <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (batch_ready) begin
            state            <= S_SELECT;
            allocator_select <= SEL_ONE << k;
          end
        end

        // select was registered on entry, so alloc_valid here refers to it
        S_SELECT: begin
          if (alloc_valid) begin
            out_data  <= captured;
            out_valid <= 1'b1;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            k         <= k_next;
            if (last_x && last_y) begin
              state            <= S_FIN;
              batch_done       <= 1'b1;
              done             <= 1'b1;
              allocator_select <= '0;
            end else begin
              if (!last_x) begin
                center_x <= x_step;
                out_x    <= out_x + 8'd1;
              end else begin
                center_x <= {7'd0, cfg_pad};
                center_y <= y_step;
                out_x    <= '0;
                out_y    <= out_y + 8'd1;
              end
              out_addr <= out_addr + ADDR_WIDTH'(1);
              if (k == K_LAST) begin
                state            <= S_BEND;
                batch_done       <= 1'b1;
                allocator_select <= '0;
              end else begin
                state            <= S_SELECT;
                allocator_select <= SEL_ONE << k_next;
              end
            end
          end
        end

        S_BEND: begin
          batch_done <= 1'b0;
          k          <= '0;
          state      <= S_IDLE;
        end

        S_FIN: begin
          batch_done <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_positioner.sv
module tb_retire_positioner;

  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    image_dim;
  logic [1:0]    padding;
  logic [2:0]    stride;
  logic          batch_ready;
  logic [NA-1:0] allocator_select;
  logic [15:0]   alloc_result;
  logic          alloc_valid;
  logic [15:0]   out_data;
  logic [7:0]    out_x;
  logic [7:0]    out_y;
  logic [15:0]   out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          batch_done;
  logic          done;

  int checks = 0;
  int errors = 0;

  retire_positioner #(.NUM_ALLOCATORS(NA), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .image_dim(image_dim), .padding(padding), .stride(stride),
    .batch_ready(batch_ready), .allocator_select(allocator_select),
    .alloc_result(alloc_result), .alloc_valid(alloc_valid), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .batch_done(batch_done), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dim; int pad; int st; int rdy; int vld;
    int total; int lx; int ly; int la;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef RETIRE_RELU_EN
    return v[15] ? 16'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic do_reset(input int dim, input int pad, input int st);
    @(negedge clk);
    image_dim = 8'(dim); padding = 2'(pad); stride = 3'(st);
    rst = 1'b1; batch_ready = 1'b0; alloc_valid = 1'b0; out_ready = 1'b0;
    alloc_result = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full map drain with random handshakes, checked every cycle against a
  // transaction-level model: result i sits at (i mod n, i div n), address i,
  // and a batch closes after every NA-th result or the last one.
  task automatic run_map(input int dim, input int pad, input int st,
                         input int rdy_pct, input int vld_pct,
                         output int acc, output int lx, output int ly, output int la,
                         output int total);
    int n, i, cyc, budget;
    bit active, exp_valid, exp_bd, nbd, br, av, rd;
    logic [15:0] exp_data, v;
    logic [NA-1:0] exp_sel;
    logic [NA-1:0] one;
    one = 1;
    n = 0;
    for (int c = pad; c <= dim - 1 + pad; c += st) n++;
    total = n * n;
    budget = total * 60 + 100;
    do_reset(dim, pad, st);
    i = 0; cyc = 0; acc = 0; lx = -1; ly = -1; la = -1;
    active = 0; exp_valid = 0; exp_bd = 0; exp_sel = '0; exp_data = '0;
    forever begin
      check("select", allocator_select, exp_sel);
      check("out_valid", out_valid, exp_valid);
      check("batch_done", batch_done, exp_bd);
      check("done", done, (i == total));
      if (exp_valid) begin
        check("out_data", out_data, exp_data);
        check("out_x", out_x, i % n);
        check("out_y", out_y, i / n);
        check("out_addr", out_addr, i & 16'hFFFF);
      end
      if (i == total && !exp_bd) break;
      br = !active && !exp_bd && (i < total) && ($urandom_range(99) < 50);
      av = ($urandom_range(99) < vld_pct);
      rd = ($urandom_range(99) < rdy_pct);
      v  = 16'($urandom);
      batch_ready = br; alloc_valid = av; alloc_result = v; out_ready = rd;
      if (out_valid && rd) begin
        acc++; lx = out_x; ly = out_y; la = out_addr;
      end
      nbd = 0;
      if (br) begin
        active = 1;
        exp_sel = one << (i % NA);
      end else if (active && !exp_valid && av) begin
        exp_valid = 1;
        exp_data = relu(v);
      end else if (exp_valid && rd) begin
        exp_valid = 0;
        i++;
        if ((i % NA) == 0 || i == total) begin
          active = 0; exp_sel = '0; nbd = 1;
        end else begin
          exp_sel = one << (i % NA);
        end
      end
      exp_bd = nbd;
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        check("run_timeout", cyc, budget);
        break;
      end
    end
    batch_ready = 0; alloc_valid = 0; out_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_select"}, allocator_select, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_x"}, out_x, 0);
    check({tag, "_y"}, out_y, 0);
    check({tag, "_addr"}, out_addr, 0);
    check({tag, "_bd"}, batch_done, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int acc, lx, ly, la, total;
    int wait_cyc;

    vecs[0] = '{4,   1, 1, 100, 100,   16,  3,  3,   15};
    vecs[1] = '{5,   0, 2, 100, 100,    9,  2,  2,    8};
    vecs[2] = '{1,   0, 1,  60,  60,    1,  0,  0,    0};
    vecs[3] = '{8,   2, 3,  50,  50,    9,  2,  2,    8};
    vecs[4] = '{6,   0, 5,  70,  40,    4,  1,  1,    3};
    vecs[5] = '{7,   3, 7,  50,  50,    1,  0,  0,    0};
    vecs[6] = '{10,  1, 3,  80,  80,   16,  3,  3,   15};
    vecs[7] = '{255, 3, 7, 100, 100, 1369, 36, 36, 1368};

    rst = 1'b1; image_dim = 8'd5; padding = 2'd0; stride = 3'd2;
    batch_ready = 0; alloc_valid = 0; alloc_result = 0; out_ready = 0;

    // reset state
    do_reset(5, 0, 2);
    check_reset_outputs("reset");

    // stall in SEND, then alloc_valid low in SELECT, with a negative result
    batch_ready = 1;
    @(negedge clk);
    batch_ready = 0;
    check("sel_first", allocator_select, 4'b0001);
    alloc_valid = 1; alloc_result = 16'hFFFB; out_ready = 0;
    @(negedge clk);
    alloc_valid = 0;
    check("neg_valid", out_valid, 1);
    check("neg_data", out_data, relu(16'hFFFB));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, relu(16'hFFFB));
      check("stall_addr", out_addr, 0);
      check("stall_sel", allocator_select, 4'b0001);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("release_valid", out_valid, 0);
    check("release_sel", allocator_select, 4'b0010);
    check("release_x", out_x, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("avlow_valid", out_valid, 0);
      check("avlow_sel", allocator_select, 4'b0010);
    end
    alloc_valid = 1; alloc_result = 16'd7;
    @(negedge clk);
    alloc_valid = 0;
    check("pos_valid", out_valid, 1);
    check("pos_data", out_data, 7);
    check("pos_addr", out_addr, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("nodup_valid", out_valid, 0);
    check("nodup_sel", allocator_select, 4'b0100);
    @(negedge clk);
    check("nodup_valid2", out_valid, 0);

    // reset at k=2 aborts the batch
    rst = 1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 0;
    batch_ready = 1; alloc_valid = 1; alloc_result = 16'd42; out_ready = 0;
    @(negedge clk);
    batch_ready = 0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    alloc_valid = 0;
    check("rerun_valid", out_valid, 1);
    check("rerun_addr", out_addr, 0);
    check("rerun_x", out_x, 0);
    check("rerun_y", out_y, 0);
    check("rerun_data", out_data, 42);

    // table-driven maps
    for (int t = 0; t < 8; t++) begin
      run_map(vecs[t].dim, vecs[t].pad, vecs[t].st, vecs[t].rdy, vecs[t].vld,
              acc, lx, ly, la, total);
      check("tbl_count", acc, vecs[t].total);
      check("tbl_last_x", lx, vecs[t].lx);
      check("tbl_last_y", ly, vecs[t].ly);
      check("tbl_last_addr", la, vecs[t].la);
    end

    // random configurations
    for (int r = 0; r < 6; r++) begin
      int d, p, s;
      d = $urandom_range(24, 1);
      p = $urandom_range(3, 0);
      s = $urandom_range(7, 1);
      run_map(d, p, s, $urandom_range(100, 30), $urandom_range(100, 30),
              acc, lx, ly, la, total);
      check("rnd_count", acc, total);
      check("rnd_last_addr", la, total - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
